// File: rtl/packed_array_unpacker.sv
// Receives a packed 4-lane word, verifies lane3 == lane0 + lane1, and streams the data lanes out
// one per handshake. Define PACKED_UNPACK_EMIT_CHECK_EN to also emit the check lane as lane 3.
module packed_array_unpacker #(
    parameter int LANE_W    = 8,
    parameter int ERR_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*LANE_W-1:0]   in_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANE_W-1:0]     out_data,
    output logic [1:0]            out_idx,
    output logic                  out_last,
    output logic                  chk_err,
    output logic [ERR_CNT_W-1:0]  err_count
);

`ifdef PACKED_UNPACK_EMIT_CHECK_EN
    localparam logic [1:0] LAST_IDX = 2'd3;
`else
    localparam logic [1:0] LAST_IDX = 2'd2;
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [LANE_W-1:0]    r_lane [4];
    logic [1:0]           r_idx;
    logic                 r_chk_err;
    logic [ERR_CNT_W-1:0] r_err_count;

    logic                 w_accept;
    logic                 w_emit_hs;
    logic                 w_is_last;
    logic                 w_check_ok;
    logic [LANE_W-1:0]    w_sum;

    // The carry out of the lane sum is deliberately dropped: the check lane wraps modulo 2^LANE_W.
    assign w_sum      = in_word[0 +: LANE_W] + in_word[LANE_W +: LANE_W];
    assign w_check_ok = (w_sum == in_word[3*LANE_W +: LANE_W]);
    assign w_accept   = in_valid && in_ready;
    assign w_is_last  = (r_idx == LAST_IDX);
    assign w_emit_hs  = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first, otherwise a latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept && w_check_ok) w_next_state = S_EMIT;
            S_EMIT: if (w_emit_hs && w_is_last) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (r_state)
            S_IDLE: in_ready = 1'b1;
            S_EMIT: begin
                out_valid = 1'b1;
                out_last  = w_is_last;
            end
            default: in_ready = 1'b0;
        endcase
    end

    assign out_data  = r_lane[r_idx];
    assign out_idx   = r_idx;
    assign chk_err   = r_chk_err;
    assign err_count = r_err_count;

    // NOTE: the lane storage is reset too, so out_data reads zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) r_lane[k] <= '0;
        end else if (w_accept) begin
            for (int k = 0; k < 4; k++) r_lane[k] <= in_word[k*LANE_W +: LANE_W];
        end
    end

    // Index returns to zero after the final lane so out_last stays low while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= 2'd0;
        end else if (w_accept) begin
            r_idx <= 2'd0;
        end else if (w_emit_hs) begin
            r_idx <= w_is_last ? 2'd0 : r_idx + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_err   <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_chk_err <= w_accept && !w_check_ok;
            if (w_accept && !w_check_ok && (r_err_count != '1)) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_packed_array_unpacker.sv
// Randomised bench for packed_array_unpacker: a queue-based model of the emitted lane stream plus
// directed checks that pin the model to hand-computed values.
module tb_packed_array_unpacker;

`ifdef PACKED_UNPACK_EMIT_CHECK_EN
    localparam int LAST = 3;
`else
    localparam int LAST = 2;
`endif

    typedef struct {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } lane_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_data;
    logic [1:0]  out_idx;
    logic        out_last;
    logic        chk_err;
    logic [7:0]  err_count;

    int checks = 0;
    int failures = 0;

    lane_t      q[$];
    logic [7:0] emitted[$];
    logic       model_chk = 1'b0;
    int         model_err = 0;
    int         chk_pulses = 0;

    packed_array_unpacker #(.LANE_W(8), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_last(out_last),
        .chk_err(chk_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word with a matching check lane becomes a queue of lanes; a bad one schedules a pulse.
    always @(posedge clk) begin
        logic [31:0] w;
        logic [7:0]  sum;
        logic        chk_n;
        if (!rst_n) begin
            q.delete();
            model_chk = 1'b0;
            model_err = 0;
        end else begin
            chk_n = 1'b0;
            if (out_valid && out_ready && q.size() > 0) begin
                emitted.push_back(out_data);
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                w   = in_word;
                sum = w[7:0] + w[15:8];
                if (sum == w[31:24]) begin
                    for (int k = 0; k <= LAST; k++)
                        q.push_back('{data: w[k*8 +: 8], idx: 2'(k), last: (k == LAST)});
                end else begin
                    chk_n = 1'b1;
                    if (model_err < 255) model_err++;
                end
            end
            model_chk = chk_n;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", 32'(out_valid), 0);
            check("rst_out_data", 32'(out_data), 0);
            check("rst_out_idx", 32'(out_idx), 0);
            check("rst_out_last", 32'(out_last), 0);
            check("rst_chk_err", 32'(chk_err), 0);
            check("rst_err_count", 32'(err_count), 0);
        end else begin
            check("in_ready", 32'(in_ready), 32'(q.size() == 0));
            check("out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("chk_err", 32'(chk_err), 32'(model_chk));
            check("err_count", 32'(err_count), 32'(model_err));
            if (chk_err) chk_pulses++;
            if (q.size() > 0) begin
                check("out_data", 32'(out_data), 32'(q[0].data));
                check("out_idx", 32'(out_idx), 32'(q[0].idx));
                check("out_last", 32'(out_last), 32'(q[0].last));
            end
        end
    end

    // All tasks start and end on a falling edge.
    task automatic send(input logic [31:0] w);
        int t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("send_timeout", 1, 0);
        in_valid = 1'b1;
        in_word  = w;
        @(negedge clk);
        in_valid = 1'b0;
        in_word  = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) check("drain_timeout", 1, 0);
        @(negedge clk);
    endtask

    task automatic check_emitted(input string name, input logic [7:0] e[$]);
        check({name, "_len"}, 32'(emitted.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < emitted.size(); i++)
            check(name, 32'(emitted[i]), 32'(e[i]));
    endtask

    function automatic logic [31:0] gen_word(input bit good);
        logic [7:0] l0, l1, l2, l3;
        l0 = 8'($urandom);
        l1 = 8'($urandom);
        l2 = 8'($urandom);
        l3 = good ? 8'(l0 + l1) : 8'(l0 + l1 + 8'($urandom_range(1, 255)));
        return {l3, l2, l1, l0};
    endfunction

    initial begin
        logic [7:0] e[$];
        logic       rdy_prev;
        int         pulses0;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Good word streams its data lanes in order.
        emitted.delete();
        send(32'h46563412);
        drain();
        e = '{8'h12, 8'h34, 8'h56};
        if (LAST == 3) e.push_back(8'h46);
        check_emitted("good_word", e);

        // The check lane wraps modulo 256.
        emitted.delete();
        send(32'h10AAF020);
        drain();
        e = '{8'h20, 8'hF0, 8'hAA};
        if (LAST == 3) e.push_back(8'h10);
        check_emitted("carry_wrap", e);

        // A bad word pulses chk_err once and emits nothing.
        emitted.delete();
        send(32'h00563412);
        check("bad_chk_err", 32'(chk_err), 1);
        check("bad_out_valid", 32'(out_valid), 0);
        check("bad_err_count", 32'(err_count), 1);
        @(negedge clk);
        check("bad_chk_err_clear", 32'(chk_err), 0);
        check("bad_no_emit", 32'(emitted.size()), 0);

        // Backpressure holds the first lane stable.
        out_ready = 1'b0;
        send(32'h46563412);
        for (int i = 0; i < 5; i++) begin
            check("bp_data", 32'(out_data), 32'h12);
            check("bp_idx", 32'(out_idx), 0);
            check("bp_in_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();
        e = '{8'h12, 8'h34, 8'h56};
        if (LAST == 3) e.push_back(8'h46);
        check_emitted("bp_word", e);

        // Reset after the first lane handshake drops the word immediately.
        emitted.delete();
        send(32'h46563412);
        @(negedge clk);
        check("pre_rst_idx", 32'(out_idx), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_now_out_valid", 32'(out_valid), 0);
        check("rst_now_out_idx", 32'(out_idx), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 1);
        check("post_rst_err_count", 32'(err_count), 0);
        emitted.delete();
        send(32'h46563412);
        check("post_rst_first_idx", 32'(out_idx), 0);
        drain();
        e = '{8'h12, 8'h34, 8'h56};
        if (LAST == 3) e.push_back(8'h46);
        check_emitted("post_rst_word", e);

        // 260 back-to-back bad words saturate the counter and pulse every time.
        pulses0 = chk_pulses;
        in_valid = 1'b1;
        for (int i = 0; i < 260; i++) begin
            in_word = gen_word(1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("sat_err_count", 32'(err_count), 255);
        check("sat_pulses", 32'(chk_pulses - pulses0), 260);

        // Random mix of good/bad words with random downstream stalls.
        rdy_prev = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!in_valid || rdy_prev) begin
                in_valid = ($urandom_range(0, 2) != 0);
                in_word  = gen_word(1'($urandom_range(0, 1)));
            end
            rdy_prev  = in_ready;
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
